// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encoding,
// saturating counter arithmetic, PC index/tag split and the BTB entry view.
package bp_pkg;

    localparam int BP_MAX_W = 64;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_t;

    // Widths are fixed at BP_MAX_W so one type serves every ADDR_W up to 64.
    typedef struct packed {
        logic [BP_MAX_W-1:0] tag;
        logic [BP_MAX_W-1:0] target;
        bp_ctr_t             ctr;
    } bp_entry_t;

    function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
        return (c == CTR_ST) ? CTR_ST : bp_ctr_t'(c + 2'd1);
    endfunction

    function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : bp_ctr_t'(c - 2'd1);
    endfunction

    function automatic logic [BP_MAX_W-1:0] bp_index(input logic [BP_MAX_W-1:0] pc,
                                                     input int idx_w);
        return (pc >> 2) & ((BP_MAX_W'(1) << idx_w) - BP_MAX_W'(1));
    endfunction

    // The caller zero-extends pc from ADDR_W, so the upper bits of the tag are zero.
    function automatic logic [BP_MAX_W-1:0] bp_tag(input logic [BP_MAX_W-1:0] pc,
                                                   input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. IF looks it up combinationally;
// ID resolves branches, reports mispredicts and trains the table.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b10,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam bp_ctr_t CTR_INIT_C = bp_ctr_t'(CTR_INIT);

    // Valid bits live apart from the payload so a flush is one vector clear.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    bp_ctr_t            ctr_q    [ENTRIES];

    logic [IDX_W-1:0]    lk_idx;
    logic [BP_MAX_W-1:0] lk_tag;
    bp_entry_t           rd_entry;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign lk_idx = IDX_W'(bp_index(BP_MAX_W'(lookup_pc), IDX_W));
    assign lk_tag = bp_tag(BP_MAX_W'(lookup_pc), IDX_W);
    assign up_idx = IDX_W'(bp_index(BP_MAX_W'(upd_pc), IDX_W));
    assign up_tag = TAG_W'(bp_tag(BP_MAX_W'(upd_pc), IDX_W));

    // Lookup reads registered state only, so a same-cycle update is not visible.
    always_comb begin
        rd_entry        = '0;
        rd_entry.tag    = BP_MAX_W'(tag_q[lk_idx]);
        rd_entry.target = BP_MAX_W'(target_q[lk_idx]);
        rd_entry.ctr    = ctr_q[lk_idx];
        pred_hit        = valid_q[lk_idx] && (rd_entry.tag == lk_tag);
        pred_taken      = pred_hit && rd_entry.ctr[1];
        pred_target     = pred_taken ? ADDR_W'(rd_entry.target) : lookup_pc + ADDR_W'(4);
    end

    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

    // Flush takes priority over training; only taken misses allocate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT_C;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= upd_taken ? ctr_inc(ctr_q[up_idx]) : ctr_dec(ctr_q[up_idx]);
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_INIT_C;
            end
        end
    end

    bp_stat_counter #(.W(STAT_W)) u_stat_lookups (
        .clk   (clk),
        .rst   (rst),
        .inc   (lookup_en),
        .count (stat_lookups)
    );

    bp_stat_counter #(.W(STAT_W)) u_stat_hits (
        .clk   (clk),
        .rst   (rst),
        .inc   (lookup_en && pred_hit),
        .count (stat_hits)
    );

    bp_stat_counter #(.W(STAT_W)) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (stat_mispredicts)
    );

endmodule
